demux_tdm_sequencer: RTL and testbench

//  Upstream driver for the 1:4 demux. Accepts a serial bit stream over a

---
 rtl/demux_tdm_sequencer.sv | 148 ++++++++++++++
 tb/tb_demux_tdm_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_tdm_sequencer.sv
// Round-robin TDM sequencer feeding a 1:4 demux; one-cycle accept-to-slot latency.
// Backpressure: din_ready low while a slot is held, the current channel is masked, or not running.
module demux_tdm_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int FRAME_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         ch_mask,
  input  logic               din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               dmx_in,
  output logic               s1,
  output logic               s0,
  output logic               dmx_strobe,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_done,
  output logic               err_nomask
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cur_ch_q, cur_ch_d;
  logic [1:0]         sel_q, sel_d;
  logic               dmx_in_q, dmx_in_d;
  logic               strobe_q, strobe_d;
  logic               frame_done_q, frame_done_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               mask_any;
  logic               accept;

  // Next enabled channel strictly above cur, wrapping; cur itself if it is the only one.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] cand;
    r = cur;
    for (int i = 3; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (m[cand]) r = cand;
    end
    return r;
  endfunction

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] highest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) r = 2'(i);
    return r;
  endfunction

  assign mask_any   = |ch_mask;
  assign din_ready  = (state_q == RUN) && ch_mask[cur_ch_q];
  assign accept     = din_valid && din_ready;
  assign err_nomask = en && !mask_any;

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    sel_d        = sel_q;
    dmx_in_d     = dmx_in_q;
    strobe_d     = strobe_q;
    frame_cnt_d  = frame_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        strobe_d = 1'b0;
        dmx_in_d = 1'b0;
        if (en && mask_any) begin
          cur_ch_d = lowest_ch(ch_mask);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          dmx_in_d = din;
          sel_d    = cur_ch_q;
          strobe_d = 1'b1;
          cur_ch_d = next_ch(cur_ch_q, ch_mask);
          if (cur_ch_q == highest_ch(ch_mask)) begin
            frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
            frame_done_d = 1'b1;
          end
          if (HOLD_CYCLES > 1) begin
            state_d    = HOLD;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
          end else if (!en || !mask_any) begin
            state_d = IDLE;
          end
        end else begin
          strobe_d = 1'b0;
          dmx_in_d = 1'b0;
          if (!en || !mask_any) state_d = IDLE;
          else if (!ch_mask[cur_ch_q]) cur_ch_d = next_ch(cur_ch_q, ch_mask);
        end
      end
      HOLD: begin
        // Strobe stays up through the exit edge so the slot spans HOLD_CYCLES cycles.
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q == HW'(1)) state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_ch_q     <= 2'd0;
      sel_q        <= 2'd0;
      dmx_in_q     <= 1'b0;
      strobe_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      sel_q        <= sel_d;
      dmx_in_q     <= dmx_in_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign dmx_in     = dmx_in_q;
  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign dmx_strobe = strobe_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_tdm_sequencer.sv
// Directed bench: instance a (HOLD 1), h (HOLD 3) and w (FRAME_W 2) share the stimulus.
module tb_demux_tdm_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, din, din_valid;
  logic [3:0] ch_mask;

  logic       a_ready, a_dmx, a_s1, a_s0, a_strobe, a_fd, a_err;
  logic [7:0] a_cnt;
  logic       h_ready, h_dmx, h_s1, h_s0, h_strobe, h_fd, h_err;
  logic [7:0] h_cnt;
  logic       w_ready, w_dmx, w_s1, w_s0, w_strobe, w_fd, w_err;
  logic [1:0] w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_tdm_sequencer #(.HOLD_CYCLES(1), .FRAME_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .din(din), .din_valid(din_valid),
    .din_ready(a_ready), .dmx_in(a_dmx), .s1(a_s1), .s0(a_s0), .dmx_strobe(a_strobe),
    .frame_cnt(a_cnt), .frame_done(a_fd), .err_nomask(a_err));

  demux_tdm_sequencer #(.HOLD_CYCLES(3), .FRAME_W(8)) u_h (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .din(din), .din_valid(din_valid),
    .din_ready(h_ready), .dmx_in(h_dmx), .s1(h_s1), .s0(h_s0), .dmx_strobe(h_strobe),
    .frame_cnt(h_cnt), .frame_done(h_fd), .err_nomask(h_err));

  demux_tdm_sequencer #(.HOLD_CYCLES(1), .FRAME_W(2)) u_w (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .din(din), .din_valid(din_valid),
    .din_ready(w_ready), .dmx_in(w_dmx), .s1(w_s1), .s0(w_s0), .dmx_strobe(w_strobe),
    .frame_cnt(w_cnt), .frame_done(w_fd), .err_nomask(w_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ch_mask = 4'h0; din = 1'b0; din_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic start(input logic [3:0] m);
    ch_mask = m;
    en = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bits2;
    logic [1:0] b4;
    bits2 = 4'b1101;
    b4    = 2'b01;

    do_reset();
    check("rst_strobe", a_strobe, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ready", a_ready, 0);

    // asynchronous reset in the middle of a stream, with u_h mid-hold
    start(4'hF);
    din = 1'b1; din_valid = 1'b1;
    repeat (4) step();
    check("pre_rst_strobe", a_strobe, 1);
    check("pre_rst_cnt", a_cnt, 1);
    check("pre_rst_hstrobe", h_strobe, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_strobe", a_strobe, 0);
    check("arst_dmx", a_dmx, 0);
    check("arst_sel", {a_s1, a_s0}, 0);
    check("arst_cnt", a_cnt, 0);
    check("arst_fd", a_fd, 0);
    check("arst_hstrobe", h_strobe, 0);
    check("arst_hsel", {h_s1, h_s0}, 0);
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; ch_mask = 4'hF;
    #1 check("rel_ready0", a_ready, 0);
    step();
    check("rel_ready1", a_ready, 1);

    // round-robin over all four channels
    do_reset();
    start(4'hF);
    check("rr_ready", a_ready, 1);
    for (int i = 0; i < 4; i++) begin
      din = bits2[i]; din_valid = 1'b1;
      step();
      check("rr_sel", {a_s1, a_s0}, i);
      check("rr_dmx", a_dmx, bits2[i]);
      check("rr_strobe", a_strobe, 1);
      check("rr_fd", a_fd, (i == 3) ? 1 : 0);
    end
    din_valid = 1'b0; din = 1'b0;
    step();
    check("rr_idle_strobe", a_strobe, 0);
    check("rr_idle_dmx", a_dmx, 0);
    check("rr_idle_sel", {a_s1, a_s0}, 3);
    check("rr_idle_fd", a_fd, 0);
    check("rr_cnt", a_cnt, 1);

    // masked channels are skipped; mask change makes a one-cycle seek
    do_reset();
    start(4'b1010);
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = i[0];
      step();
      check("mask_sel", {a_s1, a_s0}, (i % 2) ? 3 : 1);
      check("mask_fd", a_fd, i % 2);
      check("mask_dmx", a_dmx, i % 2);
    end
    check("mask_cnt", a_cnt, 2);
    din_valid = 1'b0;
    step();
    check("seek_ready_ch1", a_ready, 1);
    ch_mask = 4'b0100;
    #1 check("seek_ready_off", a_ready, 0);
    step();
    check("seek_ready_ch2", a_ready, 1);
    din = 1'b1; din_valid = 1'b1;
    step();
    check("seek_sel", {a_s1, a_s0}, 2);
    check("seek_dmx", a_dmx, 1);
    check("seek_fd", a_fd, 1);
    check("seek_cnt", a_cnt, 3);
    din_valid = 1'b0;

    // HOLD_CYCLES=3: ready 1,0,0 pattern, data stable across the slot
    do_reset();
    start(4'hF);
    din = b4[0]; din_valid = 1'b1;
    #1 check("hold_ready0", h_ready, 1);
    for (int j = 0; j < 6; j++) begin
      step();
      check("hold_ready", h_ready, (j % 3 == 2) ? 1 : 0);
      check("hold_strobe", h_strobe, 1);
      check("hold_sel", {h_s1, h_s0}, j / 3);
      check("hold_dmx", h_dmx, b4[j / 3]);
      if (j == 5) din_valid = 1'b0;
      else if (j % 3 == 2) din = b4[j / 3 + 1];
      else din = ~b4[j / 3];
    end

    // empty mask error, then en dropped during a hold
    do_reset();
    ch_mask = 4'h0; en = 1'b1;
    #1 check("err_on", a_err, 1);
    step();
    check("err_ready", a_ready, 0);
    check("err_strobe", a_strobe, 0);
    check("err_still", a_err, 1);
    en = 1'b0;
    #1 check("err_off", a_err, 0);

    do_reset();
    start(4'hF);
    din = 1'b1; din_valid = 1'b1;
    step();
    check("en0_strobe_a", h_strobe, 1);
    din_valid = 1'b0; en = 1'b0;
    step();
    check("en0_strobe_b", h_strobe, 1);
    step();
    check("en0_strobe_c", h_strobe, 1);
    check("en0_ready_c", h_ready, 0);
    step();
    check("en0_strobe_end", h_strobe, 0);
    check("en0_dmx_end", h_dmx, 0);
    check("en0_ready_end", h_ready, 0);

    // FRAME_W=2 wrap with a single enabled channel
    do_reset();
    start(4'b0001);
    din = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wrap_cnt", w_cnt, (i + 1) % 4);
      check("wrap_fd", w_fd, 1);
      check("wrap_sel", {w_s1, w_s0}, 0);
    end
    din_valid = 1'b0;
    step();
    check("wrap_fd_off", w_fd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
